// File: rtl/pcs_tx_fifo_pkg.sv
// Shared definitions for the PCS TX CDC FIFO controllers: idle-run FSM states,
// default geometry/watermarks and the binary-to-Gray helper.
package pcs_tx_fifo_pkg;

  typedef enum logic [1:0] {
    S_DATA      = 2'd0,
    S_IDLE_KEEP = 2'd1,
    S_IDLE_DEL  = 2'd2
  } idle_state_e;

  localparam int unsigned ADDRSIZE_DEF = 5;
  localparam int unsigned HI_MARK_DEF  = 24;
  localparam int unsigned AF_MARK_DEF  = 28;

  // Callers zero-extend into 16 bits and truncate the result back to their width.
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/pcs_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down);
// shared by the read- and write-side FIFO controllers.
module pcs_gray2bin #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/pcs_tx_fifo_wctl.sv
// Write-side controller for the PCS TX CDC FIFO: write pointers, full/level
// tracking against the synchronised read pointer, and idle deletion when hot.
module pcs_tx_fifo_wctl
  import pcs_tx_fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF,
  parameter int unsigned HI_MARK  = HI_MARK_DEF,
  parameter int unsigned AF_MARK  = AF_MARK_DEF
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                in_valid,
  input  logic                in_idle,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                winc,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic [15:0]         del_cnt,
  output logic                ovf
);

  localparam int unsigned AW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] HI_LVL = AW'(HI_MARK);
  localparam logic [ADDRSIZE:0] AF_LVL = AW'(AF_MARK);

  idle_state_e       state_q, state_d;
  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic [ADDRSIZE:0] rbin;
  logic              wfull_q, wfull_d;
  logic              waf_q, waf_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       del_cnt_q, del_cnt_d;
  logic              del_now, winc_c, del_inc, ovf_set;

  pcs_gray2bin #(.W(AW)) u_rptr_g2b (
    .gray_i (wq2_rptr),
    .bin_o  (rbin)
  );

  // FSM state register
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state_q <= S_IDLE_KEEP;
    else         state_q <= state_d;
  end

  // Only blocks actually written advance the idle run; deleted or dropped ones do not.
  always_comb begin
    state_d = state_q;
    if (winc_c) begin
      if (!in_idle) begin
        state_d = S_DATA;
      end else begin
        unique case (state_q)
          S_DATA:      state_d = S_IDLE_KEEP;
          S_IDLE_KEEP: state_d = S_IDLE_DEL;
          S_IDLE_DEL:  state_d = S_IDLE_DEL;
          default:     state_d = S_DATA;
        endcase
      end
    end
  end

  // An idle arriving while full mid-run counts as a deletion, not an overflow.
  always_comb begin
    del_now = in_valid & in_idle & (state_q == S_IDLE_DEL) & (wlevel_q >= HI_LVL);
    winc_c  = wrst_n & in_valid & ~wfull_q & ~del_now;
    del_inc = del_now | (in_valid & in_idle & wfull_q & (state_q != S_DATA));
    ovf_set = in_valid & wfull_q & ~del_inc;
  end

  always_comb begin
    wbin_d    = wbin_q + {{ADDRSIZE{1'b0}}, winc_c};
    wptr_d    = AW'(bin2gray(16'(wbin_d)));
    wfull_d   = (wptr_d == {~wq2_rptr[ADDRSIZE -: 2], wq2_rptr[ADDRSIZE-2:0]});
    wlevel_d  = wbin_d - rbin;
    waf_d     = (wlevel_d >= AF_LVL);
    ovf_d     = ovf_q | ovf_set;
    del_cnt_d = del_cnt_q;
    if (del_inc && (del_cnt_q != '1)) del_cnt_d = del_cnt_q + 16'd1;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q    <= '0;
      wptr_q    <= '0;
      wlevel_q  <= '0;
      wfull_q   <= 1'b0;
      waf_q     <= 1'b0;
      ovf_q     <= 1'b0;
      del_cnt_q <= '0;
    end else begin
      wbin_q    <= wbin_d;
      wptr_q    <= wptr_d;
      wlevel_q  <= wlevel_d;
      wfull_q   <= wfull_d;
      waf_q     <= waf_d;
      ovf_q     <= ovf_d;
      del_cnt_q <= del_cnt_d;
    end
  end

  assign winc         = winc_c;
  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = waf_q;
  assign wlevel       = wlevel_q;
  assign del_cnt      = del_cnt_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_pcs_tx_fifo_wctl.sv
// Directed self-checking bench for pcs_tx_fifo_wctl: fill/full/overflow,
// hot and cool idle runs, pointer wrap with a lagging reader, async reset.
module tb_pcs_tx_fifo_wctl;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        in_valid;
  logic        in_idle;
  logic [5:0]  wq2_rptr;
  logic        winc;
  logic [4:0]  waddr;
  logic [5:0]  wptr;
  logic        wfull;
  logic        walmost_full;
  logic [5:0]  wlevel;
  logic [15:0] del_cnt;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  pcs_tx_fifo_wctl #(.ADDRSIZE(5), .HI_MARK(24), .AF_MARK(28)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .in_valid     (in_valid),
    .in_idle      (in_idle),
    .wq2_rptr     (wq2_rptr),
    .winc         (winc),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .del_cnt      (del_cnt),
    .ovf          (ovf)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [5:0] gray(input int b);
    logic [5:0] v;
    v = 6'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_winc"},   32'(winc), 0);
    chk({tag, "_wptr"},   32'(wptr), 0);
    chk({tag, "_waddr"},  32'(waddr), 0);
    chk({tag, "_wlevel"}, 32'(wlevel), 0);
    chk({tag, "_wfull"},  32'(wfull), 0);
    chk({tag, "_waf"},    32'(walmost_full), 0);
    chk({tag, "_ovf"},    32'(ovf), 0);
    chk({tag, "_delcnt"}, 32'(del_cnt), 0);
  endtask

  logic [4:0] idle_seq = 5'b11110;  // bit j = in_idle for block j: frame then I1..I4
  logic [4:0] hot_winc = 5'b00111;  // I3, I4 deleted

  initial begin
    wrst_n = 1'b1; in_valid = 1'b0; in_idle = 1'b0; wq2_rptr = '0;
    #1 wrst_n = 1'b0; in_valid = 1'b1;
    #2 chk_all_zero("reset");
    in_valid = 1'b0;
    tick(); tick();
    wrst_n = 1'b1;

    // Fill 32 entries with the reader parked at 0
    for (int i = 1; i <= 32; i++) begin
      in_valid = 1'b1; in_idle = 1'b0;
      #1 chk("fill_winc", 32'(winc), 1);
      tick();
      chk("fill_level", 32'(wlevel), i);
      chk("fill_af",    32'(walmost_full), (i >= 28) ? 1 : 0);
      chk("fill_full",  32'(wfull), (i == 32) ? 1 : 0);
      chk("fill_waddr", 32'(waddr), i % 32);
    end
    chk("full_wptr", 32'(wptr), 32'h30);

    // 33rd block while full
    #1 chk("ovf_winc", 32'(winc), 0);
    tick();
    chk("ovf_flag",   32'(ovf), 1);
    chk("ovf_wptr",   32'(wptr), 32'h30);
    chk("ovf_level",  32'(wlevel), 32);
    chk("ovf_full",   32'(wfull), 1);
    chk("ovf_delcnt", 32'(del_cnt), 0);

    // Reader at 8 -> level 24: frame then four idles, hot
    in_valid = 1'b0; wq2_rptr = gray(8);
    tick();
    chk("hot_level", 32'(wlevel), 24);
    chk("hot_full",  32'(wfull), 0);
    chk("hot_ovf",   32'(ovf), 1);
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; in_idle = idle_seq[j];
      #1 chk("hot_winc", 32'(winc), 32'(hot_winc[j]));
      tick();
    end
    chk("hot_delcnt", 32'(del_cnt), 2);
    chk("hot_level2", 32'(wlevel), 27);
    chk("hot_waddr",  32'(waddr), 3);

    // Reader at 25 -> level 10: same sequence, nothing deleted
    in_valid = 1'b0; in_idle = 1'b0; wq2_rptr = gray(25);
    tick();
    chk("cool_level", 32'(wlevel), 10);
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; in_idle = idle_seq[j];
      #1 chk("cool_winc", 32'(winc), 1);
      tick();
    end
    chk("cool_delcnt", 32'(del_cnt), 2);
    chk("cool_level2", 32'(wlevel), 15);

    // Clean restart before the wrap run
    in_valid = 1'b0; in_idle = 1'b0; wrst_n = 1'b0;
    #1 chk_all_zero("rst2");
    wq2_rptr = '0;
    tick();
    wrst_n = 1'b1;

    // 100 writes, reader trailing by 3 cycles; wbin wraps past 63
    for (int k = 0; k < 100; k++) begin
      in_valid = 1'b1; in_idle = 1'b0;
      wq2_rptr = gray((k >= 3) ? (k - 3) : 0);
      #1 chk("wrap_winc", 32'(winc), 1);
      tick();
      chk("wrap_level", 32'(wlevel), (k < 3) ? (k + 1) : 4);
      chk("wrap_waddr", 32'(waddr), (k + 1) % 32);
      chk("wrap_wptr",  32'(wptr), 32'(gray((k + 1) % 64)));
      chk("wrap_full",  32'(wfull), 0);
      chk("wrap_ovf",   32'(ovf), 0);
    end

    // Drain to 0 (wbin = 36), burst to level 17, then reset mid-cycle
    in_valid = 1'b0; wq2_rptr = gray(36);
    tick();
    chk("burst_level0", 32'(wlevel), 0);
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      tick();
    end
    chk("burst_level", 32'(wlevel), 17);
    chk("burst_waddr", 32'(waddr), 21);
    #2 wrst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    tick();
    chk("rst_hold_winc",  32'(winc), 0);
    chk("rst_hold_level", 32'(wlevel), 0);
    in_valid = 1'b0; wq2_rptr = '0; wrst_n = 1'b1;
    tick();
    chk("post_rst_level", 32'(wlevel), 0);
    in_valid = 1'b1;
    #1 chk("post_rst_winc", 32'(winc), 1);
    tick();
    chk("post_rst_level1", 32'(wlevel), 1);
    chk("post_rst_waddr",  32'(waddr), 1);
    in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
